// File: rtl/lsu_mem_ctrl_if.sv
// Core/memory-side bus of the load/store controller: request/response handshake
// towards the memory stage and the word-only data memory port.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;
  logic            resp_err;
  logic [XLEN-1:0] resp_rdata;
  logic            mem_we;
  logic [XLEN-1:0] mem_a;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_pc;
  logic [XLEN-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd, mem_pc
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc, mem_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd, mem_pc
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: maps byte/half/word loads and stores onto a word-only
// memory, doing read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
  parameter int XLEN        = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input logic          clk,
  input logic          reset,
  lsu_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] merge_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic            resp_valid_r;
  logic            resp_err_r;
  logic [XLEN-1:0] resp_rdata_r;

  logic            illegal_s;
  logic            misaligned_s;
  logic            err_s;
  logic [XLEN-1:0] addr_s;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] r;
    r = word;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (f3[1:0] == 2'b01) begin
      if (off[1]) r[31:16] = wdata[15:0];
      else        r[15:0]  = wdata[15:0];
    end else begin
      r = wdata;
    end
    return r;
  endfunction

  // Request decode: legality, alignment and the address to capture
  always_comb begin
    addr_s       = bus.req_addr;
    misaligned_s = 1'b0;
    if (bus.req_we) begin
      illegal_s = (bus.req_funct3 >= 3'd3);
    end else begin
      illegal_s = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    case (bus.req_funct3[1:0])
      2'b01: begin
        misaligned_s = bus.req_addr[0];
        addr_s[0]    = 1'b0;
      end
      2'b10: begin
        misaligned_s = (bus.req_addr[1:0] != 2'b00);
        addr_s[1:0]  = 2'b00;
      end
      default: misaligned_s = 1'b0;
    endcase
    err_s = illegal_s || ((CHECK_ALIGN != 1'b0) && misaligned_s);
  end

  // Control FSM with captured request and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      merge_q      <= '0;
      funct3_q     <= 3'd0;
      we_q         <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= addr_s;
            wdata_q  <= bus.req_wdata;
            pc_q     <= bus.req_pc;
            funct3_q <= bus.req_funct3;
            we_q     <= bus.req_we;
            if (err_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= '0;
            end else if (!bus.req_we) begin
              state_r <= LD;
            end else if (bus.req_funct3[1:0] == 2'b10) begin
              state_r <= WR;
            end else begin
              state_r <= RMW_RD;
            end
          end
        end
        LD: begin
          resp_rdata_r <= load_extend(bus.mem_rd, addr_q[1:0], funct3_q);
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RMW_RD: begin
          merge_q <= merge_store(bus.mem_rd, wdata_q, addr_q[1:0], funct3_q);
          state_r <= WR;
        end
        WR: begin
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= '0;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;
  // Reset gates the strobe combinationally so a write cannot land while aborting
  assign bus.mem_we     = (state_r == WR) && !reset;
  assign bus.mem_a      = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_wd     = (we_q && (funct3_q[1:0] == 2'b10)) ? wdata_q : merge_q;
  assign bus.mem_pc     = pc_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench: two controllers (alignment checking on/off) against
// word memories and a byte-level reference model.
module tb_lsu_mem_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;
  logic [31:0] memm [0:1][0:1023];
  logic [31:0] refm [0:1][0:1023];

  logic [31:0] last_rd [0:1];
  logic [31:0] last_wd [0:1];
  logic [31:0] last_wa [0:1];
  logic [31:0] last_wp [0:1];
  logic        last_err [0:1];
  int          last_lat [0:1];
  int          last_wlat [0:1];

  lsu_mem_ctrl_if #(.XLEN(32)) if0 ();
  lsu_mem_ctrl_if #(.XLEN(32)) if1 ();

  lsu_mem_ctrl #(.XLEN(32), .CHECK_ALIGN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  lsu_mem_ctrl #(.XLEN(32), .CHECK_ALIGN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign if0.mem_rd = memm[0][if0.mem_a[11:2]];
  assign if1.mem_rd = memm[1][if1.mem_a[11:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      memm[0][pre_idx] <= pre_val;
      memm[1][pre_idx] <= pre_val;
    end
    if (if0.mem_we) memm[0][if0.mem_a[11:2]] <= if0.mem_wd;
    if (if1.mem_we) memm[1][if1.mem_a[11:2]] <= if1.mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    if0.req_valid = v;  if0.req_we = we;  if0.req_funct3 = f3;
    if0.req_addr = addr; if0.req_wdata = wdata; if0.req_pc = pc;
    if1.req_valid = v;  if1.req_we = we;  if1.req_funct3 = f3;
    if1.req_addr = addr; if1.req_wdata = wdata; if1.req_pc = pc;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 10'(idx); pre_val = val;
    refm[0][idx] = val;
    refm[1][idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Byte-level reference: d = 0 checks alignment, d = 1 forces natural alignment
  task automatic model(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic e_err, output logic [31:0] e_rd, output int e_lat,
                       output logic e_w, output logic [31:0] e_wa, output logic [31:0] e_wd);
    int nbytes; int off; int sh;
    logic illegal; logic [31:0] mask; logic [31:0] word; logic [31:0] v; logic [31:0] ea;
    illegal = we ? (f3 >= 3'd3) : ((f3 == 3'd3) || (f3 >= 3'd6));
    nbytes = 1 << f3[1:0];
    off = int'(addr[1:0]) % nbytes;
    e_rd = 32'd0; e_w = 1'b0; e_wa = 32'd0; e_wd = 32'd0;
    if (illegal || (d == 0 && off != 0)) begin
      e_err = 1'b1; e_lat = 1;
    end else begin
      e_err = 1'b0;
      ea = addr - 32'(off);
      sh = 8 * int'(ea[1:0]);
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      word = refm[d][ea[11:2]];
      if (!we) begin
        v = (word >> sh) & mask;
        if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        e_rd = v; e_lat = 2;
      end else begin
        e_wd = (word & ~(mask << sh)) | ((wdata << sh) & (mask << sh));
        e_w = 1'b1; e_wa = {ea[31:2], 2'b00};
        e_lat = (nbytes == 4) ? 2 : 3;
        refm[d][ea[11:2]] = e_wd;
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
    logic e_err [0:1]; logic [31:0] e_rd [0:1]; int e_lat [0:1];
    logic e_w [0:1]; logic [31:0] e_wa [0:1]; logic [31:0] e_wd [0:1];
    logic s_rv [0:1]; logic s_re [0:1]; logic s_rr [0:1]; logic s_we [0:1];
    logic [31:0] s_rd [0:1]; logic [31:0] s_a [0:1]; logic [31:0] s_wd [0:1]; logic [31:0] s_pc [0:1];
    int wcnt [0:1]; int rcnt [0:1]; int rdy_bad [0:1];
    for (int d = 0; d < 2; d++) begin
      model(d, we, f3, addr, wdata, e_err[d], e_rd[d], e_lat[d], e_w[d], e_wa[d], e_wd[d]);
      wcnt[d] = 0; rcnt[d] = 0; rdy_bad[d] = 0;
      last_lat[d] = 0; last_wlat[d] = 0; last_err[d] = 1'b0;
      last_rd[d] = 32'd0; last_wd[d] = 32'd0; last_wa[d] = 32'd0; last_wp[d] = 32'd0;
    end
    @(negedge clk);
    drive(1'b1, we, f3, addr, wdata, pc);
    chk("accept_ready_d0", 32'(if0.req_ready), 32'd1);
    chk("accept_ready_d1", 32'(if1.req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, we, f3, addr, wdata, pc);
      s_rv[0] = if0.resp_valid; s_re[0] = if0.resp_err; s_rr[0] = if0.req_ready; s_we[0] = if0.mem_we;
      s_rd[0] = if0.resp_rdata; s_a[0] = if0.mem_a; s_wd[0] = if0.mem_wd; s_pc[0] = if0.mem_pc;
      s_rv[1] = if1.resp_valid; s_re[1] = if1.resp_err; s_rr[1] = if1.req_ready; s_we[1] = if1.mem_we;
      s_rd[1] = if1.resp_rdata; s_a[1] = if1.mem_a; s_wd[1] = if1.mem_wd; s_pc[1] = if1.mem_pc;
      for (int d = 0; d < 2; d++) begin
        if (s_rv[d]) begin
          rcnt[d]++; last_lat[d] = k; last_err[d] = s_re[d]; last_rd[d] = s_rd[d];
        end
        if (s_we[d]) begin
          wcnt[d]++; last_wlat[d] = k; last_wa[d] = s_a[d]; last_wd[d] = s_wd[d]; last_wp[d] = s_pc[d];
        end
        if ((k <= e_lat[d]) == s_rr[d]) rdy_bad[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_resp_count", d), 32'(rcnt[d]), 32'd1);
      chk($sformatf("d%0d_resp_latency", d), 32'(last_lat[d]), 32'(e_lat[d]));
      chk($sformatf("d%0d_resp_err", d), 32'(last_err[d]), 32'(e_err[d]));
      chk($sformatf("d%0d_resp_rdata", d), last_rd[d], e_rd[d]);
      chk($sformatf("d%0d_write_count", d), 32'(wcnt[d]), 32'(e_w[d]));
      chk($sformatf("d%0d_ready_profile", d), 32'(rdy_bad[d]), 32'd0);
      if (e_w[d]) begin
        chk($sformatf("d%0d_mem_a", d), last_wa[d], e_wa[d]);
        chk($sformatf("d%0d_mem_wd", d), last_wd[d], e_wd[d]);
        chk($sformatf("d%0d_mem_pc", d), last_wp[d], pc);
        chk($sformatf("d%0d_write_latency", d), 32'(last_wlat[d]), 32'(e_lat[d] - 1));
      end
    end
  endtask

  initial begin
    int bad;
    checks = 0; errors = 0;
    reset = 1'b1; pre_we = 1'b0; pre_idx = 10'd0; pre_val = 32'd0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 64; i < 256; i++) preload(i, $urandom);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flags_d0", 32'({if0.req_ready, if0.resp_valid, if0.resp_err, if0.mem_we}), 32'd8);
    chk("rst_flags_d1", 32'({if1.req_ready, if1.resp_valid, if1.resp_err, if1.mem_we}), 32'd8);
    chk("rst_rdata_d0", if0.resp_rdata, 32'd0);
    chk("rst_mem_a_d0", if0.mem_a, 32'd0);
    chk("rst_mem_wd_d0", if0.mem_wd, 32'd0);
    chk("rst_mem_pc_d0", if0.mem_pc, 32'd0);

    preload(64, 32'h8899_AABB);
    run_req(1'b0, 3'b000, 32'h102, 32'd0, 32'h4000);
    chk("lb_const", last_rd[0], 32'hFFFF_FF99);
    run_req(1'b0, 3'b100, 32'h102, 32'd0, 32'h4004);
    chk("lbu_const", last_rd[0], 32'h0000_0099);
    run_req(1'b0, 3'b001, 32'h102, 32'd0, 32'h4008);
    chk("lh_const", last_rd[0], 32'hFFFF_8899);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, 32'h400C);
    chk("lw_const", last_rd[0], 32'h8899_AABB);

    preload(128, 32'h1122_3344);
    run_req(1'b1, 3'b000, 32'h201, 32'hCAFE_00EE, 32'h4010);
    chk("sb_wd_const", last_wd[0], 32'h1122_EE44);
    chk("sb_wlat_const", 32'(last_wlat[0]), 32'd2);
    chk("sb_pc_const", last_wp[0], 32'h4010);
    chk("sb_lat_const", 32'(last_lat[0]), 32'd3);
    preload(128, 32'h1122_3344);
    run_req(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h4014);
    chk("sh_wd_const", last_wd[0], 32'hBEEF_3344);
    run_req(1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'h4018);
    chk("sw_wd_const", last_wd[0], 32'hDEAD_BEEF);
    chk("sw_wlat_const", 32'(last_wlat[0]), 32'd1);

    run_req(1'b1, 3'b010, 32'h206, 32'h1234_5678, 32'h401C);
    chk("sw_mis_err", 32'({last_err[0], last_err[1]}), 32'd2);
    chk("sw_mis_lat", 32'(last_lat[0]), 32'd1);
    chk("sw_noalign_a", last_wa[1], 32'h204);
    chk("sw_noalign_wd", last_wd[1], 32'h1234_5678);
    run_req(1'b0, 3'b001, 32'h101, 32'd0, 32'h4020);
    chk("lh_mis_err", 32'(last_err[0]), 32'd1);
    chk("lh_noalign_rd", last_rd[1], 32'hFFFF_AABB);
    run_req(1'b0, 3'b111, 32'h100, 32'd0, 32'h4024);
    chk("ld_illegal_err", 32'({last_err[0], last_err[1]}), 32'd3);

    // Reset while in WR must drop the write and the response
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 32'h300, 32'hA5A5_A5A5, 32'h4100);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'hA5A5_A5A5, 32'h4100);
    chk("wr_state_reached", 32'({if0.mem_we, if1.mem_we}), 32'd3);
    reset = 1'b1;
    #1;
    chk("wr_reset_no_we", 32'({if0.mem_we, if1.mem_we}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'({if0.req_ready, if1.req_ready}), 32'd3);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if0.resp_valid || if1.resp_valid || if0.mem_we || if1.mem_we) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    chk("abort_mem_d0", memm[0][192], refm[0][192]);
    chk("abort_mem_d1", memm[1][192], refm[1][192]);

    // Back-to-back loads: one accept per (load latency + 1) cycles
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h4200);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_ready_%0d", i), 32'(if0.req_ready), 32'((i % 3) == 0));
      chk($sformatf("b2b_resp_%0d", i), 32'(if0.resp_valid), 32'((i % 3) == 2));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 32'h4200);
    repeat (3) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = 32'h100 + 32'($urandom_range(0, 32'h2FF));
      run_req(rwe, rf3, ra, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
